serial_uart_bridge: RTL

//   8N1 UART bridge feeding the processor's serial ports: RX bytes drive serial_in/serial_valid_in;

---
 rtl/serial_uart_bridge.sv | 362 ++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/serial_uart_bridge.sv
// ----------------------------------------------------------------------------
// serial_uart_bridge
//
// 8N1 UART bridge between the single-cycle core's serial ports and a physical
// serial line. Bytes written by the core are queued in a small TX FIFO and
// shifted out on uart_txd. Bytes received on uart_rxd are queued in a small
// RX FIFO that the core reads show-ahead. Line errors are reported through
// sticky flags that the core clears with err_clr.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per UART bit (>=4, even)
//   TX_DEPTH      TX FIFO entries (power of two, >=2)
//   RX_DEPTH      RX FIFO entries (power of two, >=2)
//
// Ports
//   clock          in   system clock, all state on rising edge
//   reset          in   synchronous, active-low reset
//   proc_tx_data   in   byte from the core
//   proc_wren      in   push proc_tx_data into the TX FIFO
//   proc_tx_ready  out  TX FIFO not full
//   proc_rx_data   out  head of the RX FIFO (0 while empty)
//   proc_rx_valid  out  RX FIFO not empty
//   proc_rden      in   pop the RX FIFO head
//   err_clr        in   clear the sticky error flags
//   uart_rxd       in   asynchronous serial line in, idle high
//   uart_txd       out  serial line out, idle high
//   rx_overrun     out  sticky: received byte dropped because RX FIFO full
//   rx_frame_err   out  sticky: stop bit sampled low
//   tx_overflow    out  sticky: proc_wren while TX FIFO full
// ----------------------------------------------------------------------------
module serial_uart_bridge #(
  parameter int CLKS_PER_BIT = 16,
  parameter int TX_DEPTH     = 4,
  parameter int RX_DEPTH     = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] proc_tx_data,
  input  logic       proc_wren,
  output logic       proc_tx_ready,
  output logic [7:0] proc_rx_data,
  output logic       proc_rx_valid,
  input  logic       proc_rden,
  input  logic       err_clr,
  input  logic       uart_rxd,
  output logic       uart_txd,
  output logic       rx_overrun,
  output logic       rx_frame_err,
  output logic       tx_overflow
);

  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);

  // Last cycle of a full bit period, and last cycle of half a bit period
  // (used to land the receiver on the middle of the start bit).
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_state_e;

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic [7:0]   tx_mem_q [TX_DEPTH];
  logic [7:0]   tx_mem_d [TX_DEPTH];
  logic [TAW:0] tx_wr_q, tx_wr_d;
  logic [TAW:0] tx_rd_q, tx_rd_d;
  logic         tx_full, tx_empty, tx_push, tx_pop;
  logic [7:0]   tx_head;

  uart_state_e  tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]   tx_bit_q, tx_bit_d;
  logic [7:0]   tx_shift_q, tx_shift_d;

  logic [7:0]   rx_mem_q [RX_DEPTH];
  logic [7:0]   rx_mem_d [RX_DEPTH];
  logic [RAW:0] rx_wr_q, rx_wr_d;
  logic [RAW:0] rx_rd_q, rx_rd_d;
  logic         rx_full, rx_empty, rx_pop, rx_accept;

  logic         rx_sync1_q, rx_sync1_d;
  logic         rx_sync2_q, rx_sync2_d;
  logic         rx_prev_q, rx_prev_d;
  logic         rx_line, rx_fall;

  uart_state_e  rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]   rx_bit_q, rx_bit_d;
  logic [7:0]   rx_shift_q, rx_shift_d;
  logic         rx_push, rx_frame_evt, rx_overrun_evt, tx_overflow_evt;

  logic         rx_overrun_q, rx_overrun_d;
  logic         rx_frame_err_q, rx_frame_err_d;
  logic         tx_overflow_q, tx_overflow_d;

  // --------------------------------------------------------------------------
  // TX FIFO: pointers carry one extra wrap bit so full and empty can be told
  // apart when the index bits match.
  // --------------------------------------------------------------------------
  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign tx_full  = (tx_wr_q[TAW] != tx_rd_q[TAW]) &&
                    (tx_wr_q[TAW-1:0] == tx_rd_q[TAW-1:0]);
  assign tx_head  = tx_mem_q[tx_rd_q[TAW-1:0]];

  // A write while full is dropped even if the transmitter pops on the same
  // edge; the overflow flag records the loss.
  always_comb begin
    tx_mem_d        = tx_mem_q;
    tx_push         = proc_wren && !tx_full;
    tx_overflow_evt = proc_wren && tx_full;
    if (tx_push) begin
      tx_mem_d[tx_wr_q[TAW-1:0]] = proc_tx_data;
    end
    tx_wr_d = tx_wr_q + (TAW+1)'(tx_push);
    tx_rd_d = tx_rd_q + (TAW+1)'(tx_pop);
  end

  // --------------------------------------------------------------------------
  // TX FSM next state. At the end of the stop bit the next queued byte is
  // loaded straight into START so consecutive frames have no idle gap.
  // --------------------------------------------------------------------------
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    case (tx_state_q)
      ST_IDLE: begin
        if (!tx_empty) begin
          tx_state_d = ST_START;
          tx_shift_d = tx_head;
          tx_cnt_d   = '0;
        end
      end
      ST_START: begin
        if (tx_cnt_q == BIT_END) begin
          tx_state_d = ST_DATA;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_bit_q == 3'd7) begin
            tx_state_d = ST_STOP;
          end else begin
            tx_bit_d = tx_bit_q + 1'b1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d = '0;
          if (!tx_empty) begin
            tx_state_d = ST_START;
            tx_shift_d = tx_head;
          end else begin
            tx_state_d = ST_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = ST_IDLE;
    endcase
  end

  // TX FSM outputs: line level per state, and the FIFO pop that accompanies
  // every transition into START.
  always_comb begin
    uart_txd = 1'b1;
    tx_pop   = 1'b0;
    case (tx_state_q)
      ST_IDLE:  tx_pop   = !tx_empty;
      ST_START: uart_txd = 1'b0;
      ST_DATA:  uart_txd = tx_shift_q[0];
      ST_STOP: begin
        uart_txd = 1'b1;
        tx_pop   = (tx_cnt_q == BIT_END) && !tx_empty;
      end
      default: uart_txd = 1'b1;
    endcase
  end

  // --------------------------------------------------------------------------
  // RX line synchroniser. The extra rx_prev stage provides the previous
  // synchronised level so a start bit is recognised only on a real 1->0
  // transition; after a bad stop bit the line must return high first.
  // --------------------------------------------------------------------------
  always_comb begin
    rx_sync1_d = uart_rxd;
    rx_sync2_d = rx_sync1_q;
    rx_prev_d  = rx_sync2_q;
  end

  assign rx_line = rx_sync2_q;
  assign rx_fall = rx_prev_q && !rx_sync2_q;

  // --------------------------------------------------------------------------
  // RX FSM next state. START waits half a bit so every later sample sits in
  // the middle of its bit; a high line there is treated as a glitch.
  // --------------------------------------------------------------------------
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    case (rx_state_q)
      ST_IDLE: begin
        if (rx_fall) begin
          rx_state_d = ST_START;
          rx_cnt_d   = '0;
        end
      end
      ST_START: begin
        if (rx_cnt_q == HALF_END) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          rx_state_d = rx_line ? ST_IDLE : ST_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_line, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = ST_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d   = '0;
          rx_state_d = ST_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  // RX FSM outputs: stop-bit verdict at the middle of the stop bit.
  always_comb begin
    rx_push      = 1'b0;
    rx_frame_evt = 1'b0;
    if (rx_state_q == ST_STOP && rx_cnt_q == BIT_END) begin
      rx_push      = rx_line;
      rx_frame_evt = !rx_line;
    end
  end

  // --------------------------------------------------------------------------
  // RX FIFO. A pop on the same edge frees the slot, so a byte arriving into a
  // full FIFO that is being read is still kept.
  // --------------------------------------------------------------------------
  assign rx_empty = (rx_wr_q == rx_rd_q);
  assign rx_full  = (rx_wr_q[RAW] != rx_rd_q[RAW]) &&
                    (rx_wr_q[RAW-1:0] == rx_rd_q[RAW-1:0]);

  always_comb begin
    rx_mem_d       = rx_mem_q;
    rx_pop         = proc_rden && !rx_empty;
    rx_accept      = rx_push && (!rx_full || rx_pop);
    rx_overrun_evt = rx_push && rx_full && !rx_pop;
    if (rx_accept) begin
      rx_mem_d[rx_wr_q[RAW-1:0]] = rx_shift_q;
    end
    rx_wr_d = rx_wr_q + (RAW+1)'(rx_accept);
    rx_rd_d = rx_rd_q + (RAW+1)'(rx_pop);
  end

  // Sticky flags: a clear and a fresh event on the same edge leaves the flag set.
  always_comb begin
    rx_overrun_d   = (rx_overrun_q   && !err_clr) || rx_overrun_evt;
    rx_frame_err_d = (rx_frame_err_q && !err_clr) || rx_frame_evt;
    tx_overflow_d  = (tx_overflow_q  && !err_clr) || tx_overflow_evt;
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      tx_wr_q        <= '0;
      tx_rd_q        <= '0;
      tx_state_q     <= ST_IDLE;
      tx_cnt_q       <= '0;
      tx_bit_q       <= '0;
      tx_shift_q     <= '0;
      rx_wr_q        <= '0;
      rx_rd_q        <= '0;
      rx_sync1_q     <= 1'b1;
      rx_sync2_q     <= 1'b1;
      rx_prev_q      <= 1'b1;
      rx_state_q     <= ST_IDLE;
      rx_cnt_q       <= '0;
      rx_bit_q       <= '0;
      rx_shift_q     <= '0;
      rx_overrun_q   <= 1'b0;
      rx_frame_err_q <= 1'b0;
      tx_overflow_q  <= 1'b0;
    end else begin
      tx_wr_q        <= tx_wr_d;
      tx_rd_q        <= tx_rd_d;
      tx_state_q     <= tx_state_d;
      tx_cnt_q       <= tx_cnt_d;
      tx_bit_q       <= tx_bit_d;
      tx_shift_q     <= tx_shift_d;
      rx_wr_q        <= rx_wr_d;
      rx_rd_q        <= rx_rd_d;
      rx_sync1_q     <= rx_sync1_d;
      rx_sync2_q     <= rx_sync2_d;
      rx_prev_q      <= rx_prev_d;
      rx_state_q     <= rx_state_d;
      rx_cnt_q       <= rx_cnt_d;
      rx_bit_q       <= rx_bit_d;
      rx_shift_q     <= rx_shift_d;
      rx_overrun_q   <= rx_overrun_d;
      rx_frame_err_q <= rx_frame_err_d;
      tx_overflow_q  <= tx_overflow_d;
    end
  end

  // FIFO storage needs no reset: contents are only observed through the
  // pointers, and the RX head is masked while empty.
  always_ff @(posedge clock) begin
    tx_mem_q <= tx_mem_d;
    rx_mem_q <= rx_mem_d;
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign proc_tx_ready = !tx_full;
  assign proc_rx_valid = !rx_empty;
  assign proc_rx_data  = rx_empty ? 8'h00 : rx_mem_q[rx_rd_q[RAW-1:0]];
  assign rx_overrun    = rx_overrun_q;
  assign rx_frame_err  = rx_frame_err_q;
  assign tx_overflow   = tx_overflow_q;

endmodule
